// File: rtl/countdown_param_if.sv
// Push-button countdown bus: raw button and control strobes in, count and flags out.
interface countdown_param_if #(
  parameter int unsigned WIDTH = 7
);
  logic             button;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             zero;
  logic             wrapped;

  modport master (
    output button, enable, load, load_value,
    input  value, zero, wrapped
  );

  modport slave (
    input  button, enable, load, load_value,
    output value, zero, wrapped
  );
endinterface

// File: rtl/countdown_param.sv
// Parametrised button-driven down-counter with synchroniser, load, enable and saturate/wrap at zero.
// Define COUNTDOWN_DEBOUNCE_EN to compile in the debounce FSM; otherwise each sync1 rising edge steps.
module countdown_param #(
  parameter int unsigned WIDTH           = 7,
  parameter int unsigned START           = 63,
  parameter int unsigned MODE            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  countdown_param_if.slave bus
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("countdown_param: DEBOUNCE_CYCLES must be at least 2");
  end
  if (WIDTH < 32 && START >= (32'd1 << WIDTH)) begin : g_bad_start
    $error("countdown_param: START does not fit in WIDTH bits");
  end

  logic             sync0;
  logic             sync1;
  logic             step;
  logic [WIDTH-1:0] value_q;
  logic             wrapped_q;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= bus.button;
      sync1 <= sync0;
    end
  end

`ifdef COUNTDOWN_DEBOUNCE_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A press is accepted only after DEBOUNCE_CYCLES consecutive high samples; release likewise
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (sync1) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_CHK: begin
        if (!sync1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          step      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync1) begin
          state_nxt = REL_CHK;
          cnt_nxt   = CNT_W'(1);
        end
      end
      REL_CHK: begin
        if (sync1) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
`else
  logic sync1_q;

  // Without debounce, every rising edge of sync1 is one step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
    end else begin
      sync1_q <= sync1;
    end
  end

  assign step = sync1 & ~sync1_q;
`endif

  // Load wins over step; zero either holds or reloads START depending on MODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q   <= START_V;
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= 1'b0;
      if (bus.load) begin
        value_q <= bus.load_value;
      end else if (step && bus.enable) begin
        if (value_q != '0) begin
          value_q <= value_q - WIDTH'(1);
        end else if (MODE == 1) begin
          value_q   <= START_V;
          wrapped_q <= 1'b1;
        end
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.wrapped = wrapped_q;
  assign bus.zero    = (value_q == '0);

endmodule

// File: doc/countdown_param.md
# countdown_param

Parametrised, button-driven down-counter that generalises the team's fixed 63-to-0 countdown to any width and start value. It adds an input synchroniser, a debounce FSM, a synchronous load, an enable, and a selectable saturate or wrap mode at zero. It sits between a raw board push-button and downstream display or compare logic, and delivers one decrement per clean press.

## Interface
- `WIDTH`, default 7: width of `value` and `load_value`.
- `START`, default 63: reset and wrap-reload value; must satisfy `START < 2**WIDTH`.
- `MODE`, default 0: 0 = saturate at zero; 1 = wrap from 0 to `START`.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a press or release; must be ≥ 2.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `button` input, 1 bit: raw, asynchronous, bouncing push-button; 1 = pressed.
- `enable` input, 1 bit: 1 = accepted presses decrement; 0 = presses are discarded.
- `load` input, 1 bit: synchronous load strobe.
- `load_value` input, `WIDTH` bits: value applied on `load`.
- `value` output, `WIDTH` bits: current count (registered).
- `zero` output, 1 bit: combinational `value == 0`.
- `wrapped` output, 1 bit: registered one-cycle pulse when `value` reloads 0→`START` (MODE=1 only).

## Operation
- **Synchroniser:** two flops, `sync0` then `sync1`, both reset to 0. Only `sync1` feeds the logic below.
- **Debounce FSM** (`COUNTDOWN_DEBOUNCE_EN` defined). States IDLE, PRESS_CHK, HELD, REL_CHK. Counter `cnt` holds values 0..`DEBOUNCE_CYCLES`-1.
  - IDLE: `sync1`=1 → PRESS_CHK, `cnt`=1.
  - PRESS_CHK: `sync1`=0 → IDLE, `cnt`=0. `cnt`==`DEBOUNCE_CYCLES`-1 → HELD and assert `step`. Otherwise `cnt`++.
  - HELD: `sync1`=0 → REL_CHK, `cnt`=1.
  - REL_CHK: `sync1`=1 → HELD. `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE. Otherwise `cnt`++.
  - `step` is an internal single-cycle strobe. Only the PRESS_CHK→HELD transition produces it. Release never decrements, and holding the button never repeats.
- **Counter update priority** (highest first):
  1. `reset`.
  2. `load`: `value`←`load_value`. A `step` in the same cycle is dropped.
  3. `step & enable`:
     - `value`>0: `value`−1.
     - `value`==0, MODE=0: `value` stays 0, `wrapped` stays 0.
     - `value`==0, MODE=1: `value`←`START`, `wrapped`=1 for exactly one cycle.
- **Independence:** the FSM keeps running when `enable`=0 or `load`=1, so press tracking is never lost.
- **Arithmetic:** unsigned, `WIDTH` bits. The decrement never underflows, because the zero case is handled explicitly.

## Timing
- **Reset values:** `value`=`START`; `wrapped`=0; `zero`=(`START`==0); FSM=IDLE; `cnt`=0; sync flops=0.
- **Press latency, macro defined:** `button` rises before clock edge 1 and stays high. `value` changes on edge `DEBOUNCE_CYCLES`+2, which is edge 6 at default.
- **Press latency, macro undefined:** `value` changes on edge 3.
- **Rejected press:** a press shorter than `DEBOUNCE_CYCLES` samples of `sync1` produces no `step`.
- **Load latency:** `load` is sampled at an edge; the new `value` is visible after that same edge.
- **`wrapped` timing:** asserts after the same edge that loads `START`, and deasserts at the next edge.
- **Reset mid-press:** the FSM returns to IDLE. A still-held button is re-qualified from scratch and yields exactly one `step` after `reset` falls.

## Configuration
- Macro: `COUNTDOWN_DEBOUNCE_EN`.
- **Defined:** the debounce FSM above is compiled in, and `DEBOUNCE_CYCLES` is honoured.
- **Undefined:** the FSM and `cnt` are removed. `step` = `sync1 & ~sync1_q`, where `sync1_q` is a third flop, giving one strobe per rising edge of `sync1`. `DEBOUNCE_CYCLES` is ignored, and release is ignored.

## Test plan
All scenarios use default parameters, `enable`=1, and the macro defined unless stated.

- **Reset then press:** assert `reset` for 2 cycles, release it; `value`=63 and `zero`=0. Hold `button` for 10 cycles → `value`=62 on edge 6, and it stays 62 while held.
- **Bounce rejection:** `button` high 2 cycles, low 1, high 2, low → `value` stays 63. Repeat the bounce pattern on release after a valid press → exactly one decrement in total.
- **Saturate (MODE=0):** `load`=1 with `load_value`=1, then 2 clean presses → `value`=0, `zero`=1, `wrapped` never asserts.
- **Wrap (MODE=1):** load 0, then 1 clean press → `value`=63, `wrapped`=1 for exactly one cycle, `zero`=0.
- **Priorities:** with `enable`=0, 3 presses → `value` unchanged. With `load`=1 (`load_value`=10) on the exact edge a `step` occurs → `value`=10, not 9.
- **Reset mid-press and macro off:**
  - Macro defined: pulse `reset` while in PRESS_CHK with `button` held → `value`=63, then `value`=62 exactly `DEBOUNCE_CYCLES`+2 edges after reset release.
  - Macro undefined: a 1-cycle `button` pulse → `value`=62 on edge 3.
